// File: rtl/note_fall_sequencer.sv
// note_fall_sequencer
//   Walks a song ROM one entry at a time and presents a single falling note
//   (number + Y position) to the note register in front of the VGA renderer.
//   The active note moves down by STEP pixels on every frame_tick. It ends
//   when the player hits it or when the next step would carry it past Y_LIMIT.
//   A ROM entry of 0 marks the end of the song.
//
// Ports
//   clock        in   system clock, rising edge
//   reset_n      in   synchronous active-low reset
//   start        in   pulse: start the song at address 0 (only in IDLE/DONE)
//   frame_tick   in   pulse: once per video frame
//   hit          in   pulse: player struck the active note
//   rom_addr     out  song ROM address
//   rom_data     in   note number at rom_addr, one cycle read latency
//   note_number  out  active note number
//   note_pos_y   out  active note Y position
//   note_valid   out  note_number/note_pos_y describe a live falling note
//   hit_ack      out  pulse: hit accepted on the active note
//   song_done    out  song finished, held until the next start
module note_fall_sequencer #(
  parameter int         ADDR_W  = 8,
  parameter logic [9:0] Y_START = 10'd0,
  parameter logic [9:0] Y_LIMIT = 10'd479,
  parameter logic [9:0] STEP    = 10'd2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              frame_tick,
  input  logic              hit,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [6:0]        rom_data,
  output logic [6:0]        note_number,
  output logic [9:0]        note_pos_y,
  output logic              note_valid,
  output logic              hit_ack,
  output logic              song_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_LOAD  = 3'd3,
    S_FALL  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // A note whose Y is above this threshold would pass Y_LIMIT on its next step.
  localparam logic [9:0]        MISS_TH   = Y_LIMIT - STEP;
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1'b1);

  state_t state_r;
  logic   note_end_s;

  // Decide whether the active note finishes this cycle: a hit wins over the
  // frame tick, so a tick in the same cycle never counts as a miss.
  always_comb begin
    note_end_s = 1'b0;
    if (hit) begin
      note_end_s = 1'b1;
    end else if (frame_tick && (note_pos_y > MISS_TH)) begin
      note_end_s = 1'b1;
    end else begin
      note_end_s = 1'b0;
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r     <= S_IDLE;
      rom_addr    <= '0;
      note_number <= 7'd0;
      note_pos_y  <= Y_START;
      note_valid  <= 1'b0;
      hit_ack     <= 1'b0;
      song_done   <= 1'b0;
    end else begin
      hit_ack <= 1'b0;
      case (state_r)
        S_IDLE, S_DONE: begin
          if (start) begin
            rom_addr  <= '0;
            song_done <= 1'b0;
            state_r   <= S_FETCH;
          end
        end
        S_FETCH: state_r <= S_WAIT;
        // Gives the ROM its one cycle of read latency after an address change.
        S_WAIT:  state_r <= S_LOAD;
        S_LOAD: begin
          if (rom_data == 7'd0) begin
            song_done  <= 1'b1;
            note_valid <= 1'b0;
            state_r    <= S_DONE;
          end else begin
            note_number <= rom_data;
            note_pos_y  <= Y_START;
            note_valid  <= 1'b1;
            state_r     <= S_FALL;
          end
        end
        S_FALL: begin
          if (note_end_s) begin
            // note_number/note_pos_y keep their last values after the note ends.
            hit_ack    <= hit;
            note_valid <= 1'b0;
            if (rom_addr == ADDR_LAST) begin
              song_done <= 1'b1;
              state_r   <= S_DONE;
            end else begin
              rom_addr <= rom_addr + ADDR_ONE;
              state_r  <= S_FETCH;
            end
          end else if (frame_tick) begin
            note_pos_y <= note_pos_y + STEP;
          end
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_fall_sequencer.sv
module tb_note_fall_sequencer;

  logic       clock;
  logic       reset_n;
  logic       start, frame_tick, hit;
  logic [7:0] rom_addr;
  logic [6:0] rom_data;
  logic [6:0] note_number;
  logic [9:0] note_pos_y;
  logic       note_valid, hit_ack, song_done;

  // Second instance with a 2-bit address to exercise the end-of-ROM case.
  logic       b_start, b_frame_tick, b_hit;
  logic [1:0] b_rom_addr;
  logic [6:0] b_rom_data;
  logic [6:0] b_note_number;
  logic [9:0] b_note_pos_y;
  logic       b_note_valid, b_hit_ack, b_song_done;

  logic [6:0] rom_mem [256];
  logic [6:0] rom2 [4];

  int errors = 0;
  int checks = 0;

  note_fall_sequencer dut (
    .clock(clock), .reset_n(reset_n), .start(start), .frame_tick(frame_tick),
    .hit(hit), .rom_addr(rom_addr), .rom_data(rom_data),
    .note_number(note_number), .note_pos_y(note_pos_y),
    .note_valid(note_valid), .hit_ack(hit_ack), .song_done(song_done)
  );

  note_fall_sequencer #(.ADDR_W(2)) dut_b (
    .clock(clock), .reset_n(reset_n), .start(b_start), .frame_tick(b_frame_tick),
    .hit(b_hit), .rom_addr(b_rom_addr), .rom_data(b_rom_data),
    .note_number(b_note_number), .note_pos_y(b_note_pos_y),
    .note_valid(b_note_valid), .hit_ack(b_hit_ack), .song_done(b_song_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous ROMs: data follows the address one cycle later.
  always_ff @(posedge clock) begin
    rom_data   <= rom_mem[rom_addr];
    b_rom_data <= rom2[b_rom_addr];
  end

  // Reference model: the song as a list of notes, a countdown of cycles until
  // the next ROM entry is consumed, and the Y position as plain arithmetic.
  int m_phase;   // 0 = waiting for start, 1 = fetching next entry, 2 = note falling
  int m_cnt;
  int m_addr, m_note, m_y, m_valid, m_ack, m_done;

  task automatic model_update();
    int d;
    m_ack = 0;
    if (!reset_n) begin
      m_phase = 0; m_addr = 0; m_note = 0; m_y = 0; m_valid = 0; m_done = 0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_addr = 0; m_done = 0; m_phase = 1; m_cnt = 3;
      end
    end else if (m_phase == 1) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        d = int'(rom_mem[m_addr]);
        if (d == 0) begin
          m_done = 1; m_valid = 0; m_phase = 0;
        end else begin
          m_note = d; m_y = 0; m_valid = 1; m_phase = 2;
        end
      end
    end else begin
      if (hit || (frame_tick && (m_y + 2 > 479))) begin
        m_ack = hit ? 1 : 0;
        m_valid = 0;
        if (m_addr == 255) begin
          m_done = 1; m_phase = 0;
        end else begin
          m_addr = m_addr + 1; m_phase = 1; m_cnt = 3;
        end
      end else if (frame_tick) begin
        m_y = m_y + 2;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive main-DUT inputs, advance, update model, compare after the edge.
  task automatic step(input logic st, input logic tk, input logic ht);
    start = st; frame_tick = tk; hit = ht;
    @(posedge clock);
    model_update();
    #1;
    chk("m_valid", int'(note_valid), m_valid);
    chk("m_ack",   int'(hit_ack),    m_ack);
    chk("m_done",  int'(song_done),  m_done);
    chk("m_addr",  int'(rom_addr),   m_addr);
    chk("m_y",     int'(note_pos_y), m_y);
    chk("m_note",  int'(note_number), m_note);
    start = 1'b0; frame_tick = 1'b0; hit = 1'b0;
  endtask

  typedef struct packed {
    logic       st, tk, ht;
    logic       e_valid;
    logic [6:0] e_note;
    logic [9:0] e_y;
    logic       e_ack, e_done;
    logic [7:0] e_addr;
  } vec_t;

  vec_t tbl [15];

  initial begin
    int k;
    reset_n = 1'b0; start = 1'b0; frame_tick = 1'b0; hit = 1'b0;
    b_start = 1'b0; b_frame_tick = 1'b0; b_hit = 1'b0;
    for (int i = 0; i < 256; i++) rom_mem[i] = 7'd0;
    rom2[0] = 7'd1; rom2[1] = 7'd2; rom2[2] = 7'd3; rom2[3] = 7'd4;
    rom_mem[0] = 7'd12; rom_mem[1] = 7'd0;

    // Reset state
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("rst_valid", int'(note_valid), 0);
    chk("rst_y",     int'(note_pos_y), 0);
    chk("rst_done",  int'(song_done), 0);
    reset_n = 1'b1;

    // Test 1: reset in the middle of a falling note
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("lat_not_yet", int'(note_valid), 0);
    step(1'b0, 1'b0, 1'b0);
    chk("lat_valid", int'(note_valid), 1);
    chk("lat_note",  int'(note_number), 12);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0);
    chk("pre_rst_y", int'(note_pos_y), 40);
    reset_n = 1'b0;
    step(1'b0, 1'b1, 1'b1);
    reset_n = 1'b1;
    chk("midrst_valid", int'(note_valid), 0);
    chk("midrst_y",     int'(note_pos_y), 0);
    chk("midrst_addr",  int'(rom_addr), 0);
    step(1'b0, 1'b1, 1'b1);
    chk("midrst_idle", int'(hit_ack), 0);

    // Test 2: full fall of one note to the bottom line
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    chk("t2_valid", int'(note_valid), 1);
    chk("t2_y0",    int'(note_pos_y), 0);
    for (int i = 1; i <= 239; i++) begin
      step(1'b0, 1'b1, 1'b0);
      chk("t2_ystep", int'(note_pos_y), 2 * i);
    end
    chk("t2_still_valid", int'(note_valid), 1);
    step(1'b0, 1'b1, 1'b0);
    chk("t2_miss_end", int'(note_valid), 0);
    chk("t2_y_hold",   int'(note_pos_y), 478);
    chk("t2_no_ack",   int'(hit_ack), 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    chk("t2_done", int'(song_done), 1);

    // Test 3: hit at y=100, next note 3 cycles later
    rom_mem[0] = 7'd5; rom_mem[1] = 7'd9; rom_mem[2] = 7'd0;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    chk("t3_note5", int'(note_number), 5);
    for (int i = 0; i < 50; i++) step(1'b0, 1'b1, 1'b0);
    chk("t3_y100", int'(note_pos_y), 100);
    step(1'b0, 1'b0, 1'b1);
    chk("t3_ack", int'(hit_ack), 1);
    step(1'b0, 1'b0, 1'b0);
    chk("t3_ack_pulse", int'(hit_ack), 0);
    step(1'b0, 1'b0, 1'b0);
    chk("t3_gap", int'(note_valid), 0);
    step(1'b0, 1'b0, 1'b0);
    chk("t3_note9_valid", int'(note_valid), 1);
    chk("t3_note9", int'(note_number), 9);
    chk("t3_note9_y", int'(note_pos_y), 0);

    // Test 4: hit and tick together at the bottom
    for (int i = 0; i < 239; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    chk("t4_ack", int'(hit_ack), 1);
    chk("t4_y",   int'(note_pos_y), 478);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    chk("t4_done", int'(song_done), 1);

    // Test 5: ignored start/hit, table-driven (ROM {5,9,0}, from DONE with note 9 at 478)
    tbl[0]  = '{1'b1,1'b0,1'b0, 1'b0,7'd9,10'd478, 1'b0,1'b0, 8'd0};
    tbl[1]  = '{1'b0,1'b0,1'b1, 1'b0,7'd9,10'd478, 1'b0,1'b0, 8'd0};
    tbl[2]  = '{1'b0,1'b0,1'b1, 1'b0,7'd9,10'd478, 1'b0,1'b0, 8'd0};
    tbl[3]  = '{1'b0,1'b1,1'b0, 1'b1,7'd5,10'd0,   1'b0,1'b0, 8'd0};
    tbl[4]  = '{1'b1,1'b1,1'b0, 1'b1,7'd5,10'd2,   1'b0,1'b0, 8'd0};
    tbl[5]  = '{1'b0,1'b1,1'b0, 1'b1,7'd5,10'd4,   1'b0,1'b0, 8'd0};
    tbl[6]  = '{1'b0,1'b0,1'b1, 1'b0,7'd5,10'd4,   1'b1,1'b0, 8'd1};
    tbl[7]  = '{1'b1,1'b0,1'b0, 1'b0,7'd5,10'd4,   1'b0,1'b0, 8'd1};
    tbl[8]  = '{1'b0,1'b0,1'b1, 1'b0,7'd5,10'd4,   1'b0,1'b0, 8'd1};
    tbl[9]  = '{1'b0,1'b0,1'b0, 1'b1,7'd9,10'd0,   1'b0,1'b0, 8'd1};
    tbl[10] = '{1'b0,1'b1,1'b1, 1'b0,7'd9,10'd0,   1'b1,1'b0, 8'd2};
    tbl[11] = '{1'b0,1'b0,1'b0, 1'b0,7'd9,10'd0,   1'b0,1'b0, 8'd2};
    tbl[12] = '{1'b0,1'b0,1'b0, 1'b0,7'd9,10'd0,   1'b0,1'b0, 8'd2};
    tbl[13] = '{1'b1,1'b0,1'b0, 1'b0,7'd9,10'd0,   1'b0,1'b1, 8'd2};
    tbl[14] = '{1'b0,1'b0,1'b1, 1'b0,7'd9,10'd0,   1'b0,1'b1, 8'd2};
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].st, tbl[i].tk, tbl[i].ht);
      chk($sformatf("tbl%0d_valid", i), int'(note_valid),  int'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_note", i),  int'(note_number), int'(tbl[i].e_note));
      chk($sformatf("tbl%0d_y", i),     int'(note_pos_y),  int'(tbl[i].e_y));
      chk($sformatf("tbl%0d_ack", i),   int'(hit_ack),     int'(tbl[i].e_ack));
      chk($sformatf("tbl%0d_done", i),  int'(song_done),   int'(tbl[i].e_done));
      chk($sformatf("tbl%0d_addr", i),  int'(rom_addr),    int'(tbl[i].e_addr));
    end

    // Randomized songs and stimulus against the reference model
    for (int song = 0; song < 6; song++) begin
      k = int'($urandom_range(2, 6));
      for (int i = 0; i < 8; i++)
        rom_mem[i] = (i < k) ? 7'($urandom_range(1, 127)) : 7'd0;
      for (int c = 0; c < 700; c++) begin
        reset_n = ($urandom_range(0, 399) != 0);
        step(($urandom_range(0, 19) == 0), ($urandom_range(0, 1) == 1),
             ($urandom_range(0, 29) == 0));
      end
      reset_n = 1'b1;
    end

    // Test 6: 2-bit address, no end marker
    reset_n = 1'b1;
    b_start = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    b_start = 1'b0;
    for (int n = 0; n < 4; n++) begin
      k = 0;
      while (!b_note_valid && k < 10) begin
        step(1'b0, 1'b0, 1'b0);
        k++;
      end
      chk("t6_wait", int'(b_note_valid), 1);
      chk("t6_note", int'(b_note_number), n + 1);
      b_hit = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      b_hit = 1'b0;
      chk("t6_ack", int'(b_hit_ack), 1);
    end
    chk("t6_done",  int'(b_song_done), 1);
    chk("t6_addr",  int'(b_rom_addr), 3);
    chk("t6_valid", int'(b_note_valid), 0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
    chk("t6_addr_hold", int'(b_rom_addr), 3);
    chk("t6_done_hold", int'(b_song_done), 1);
    b_start = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    b_start = 1'b0;
    chk("t6_restart_addr", int'(b_rom_addr), 0);
    chk("t6_restart_done", int'(b_song_done), 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    chk("t6_replay_valid", int'(b_note_valid), 1);
    chk("t6_replay_note",  int'(b_note_number), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
